// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared state encoding and length helper for the stochastic bitstream decoder
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } sc_state_e;

    // Bitstream length L = 2^N for an N-bit decoded value.
    function automatic int unsigned sc_len(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// rtl/sc_ones_counter.sv - N+1-bit ones and bit counters with clear, enable and last-bit flag
module sc_ones_counter
    import sc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         bit_in,
    output logic [N:0]   ones,
    output logic [N:0]   bits,
    output logic [N:0]   ones_inc,
    output logic         last
);

    localparam logic [N:0] LAST_IDX = (N+1)'(sc_len(N) - 1);

    logic [N:0] ones_q, ones_d;
    logic [N:0] bits_q, bits_d;

    // Ones count including the bit presented this cycle; used to register the result on the last bit.
    assign ones_inc = ones_q + {{N{1'b0}}, bit_in};
    assign last     = en && (bits_q == LAST_IDX);
    assign ones     = ones_q;
    assign bits     = bits_q;

    always_comb begin
        ones_d = ones_q;
        bits_d = bits_q;
        if (clr) begin
            ones_d = '0;
            bits_d = '0;
        end else if (en) begin
            ones_d = ones_inc;
            bits_d = bits_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
            bits_q <= '0;
        end else begin
            ones_q <= ones_d;
            bits_q <= bits_d;
        end
    end

endmodule

// File: rtl/sc_bitstream_decoder.sv
// rtl/sc_bitstream_decoder.sv - decodes a 2^N-bit stochastic bitstream into its clipped ones count
module sc_bitstream_decoder
    import sc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic [N-1:0] k_out,
    output logic         k_valid,
    input  logic         k_ready,
    output logic         busy,
    output logic         sat
);

    sc_state_e    state_q, state_d;
    logic [N-1:0] k_out_q, k_out_d;
    logic         sat_q, sat_d;

    logic         cnt_clr;
    logic         cnt_en;
    logic [N:0]   cnt_ones;
    logic [N:0]   cnt_bits;
    logic [N:0]   cnt_ones_inc;
    logic         cnt_last;

    sc_ones_counter #(.N(N)) u_ones_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .bit_in   (bit_in),
        .ones     (cnt_ones),
        .bits     (cnt_bits),
        .ones_inc (cnt_ones_inc),
        .last     (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        k_out_d = k_out_q;
        sat_d   = sat_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // Abort wins even over the final bit, so no result is published.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = bit_valid;
                    if (cnt_last) begin
                        // A full stream of ones (count = L) is the only case with bit N set.
                        k_out_d = cnt_ones_inc[N] ? {N{1'b1}} : cnt_ones_inc[N-1:0];
                        sat_d   = cnt_ones_inc[N];
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (k_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_out_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_out_q <= k_out_d;
            sat_q   <= sat_d;
        end
    end

    assign k_out   = k_out_q;
    assign sat     = sat_q;
    assign k_valid = (state_q == DONE);
    assign busy    = (state_q == COUNT);

endmodule
